// File: rtl/ram_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Addresses 0 (buttons) and 1 (display register) are served locally.
module ram_bus_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              res,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ack,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ack,
   output logic              ram_sel,
   output logic              ram_ld,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic [1:0]        btn_in,
   output logic [DATA_W-1:0] hex_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, LATCH, DONE} state_t;

   state_t              state, state_nxt;
   logic                last_grant, gnt, gnt_nxt;
   logic                cmd_we;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [DATA_W-1:0]   io_data;
   logic                cmd_ram, cmd_io0, cmd_io1;

   always_ff @(posedge clk) begin
      if (res) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (m0_req || m1_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = LATCH;
         LATCH:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt = 1'b0;
      if (m0_req && m1_req) gnt_nxt = ~last_grant;
      else if (m1_req)      gnt_nxt = 1'b1;
      cmd_io0   = (cmd_addr == '0);
      cmd_io1   = (cmd_addr == ADDR_W'(1));
      cmd_ram   = (cmd_addr >= ADDR_W'(2)) && (cmd_addr < ADDR_W'(DEPTH));
      // reset masks the strobes combinationally so it wins over a same-cycle ack
      ram_sel   = (state == ACCESS) && cmd_ram && !res;
      ram_ld    = ram_sel && !cmd_we;
      ram_addr  = ram_sel ? cmd_addr  : '0;
      ram_wdata = ram_sel ? cmd_wdata : '0;
      m0_ack    = (state == DONE) && !gnt && !res;
      m1_ack    = (state == DONE) &&  gnt && !res;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         io_data    <= '0;
         hex_out    <= '0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         case (state)
            IDLE: if (m0_req || m1_req) begin
               gnt <= gnt_nxt;
               // only a contested grant moves the round-robin pointer
               if (m0_req && m1_req) last_grant <= gnt_nxt;
               cmd_we    <= gnt_nxt ? m1_we    : m0_we;
               cmd_addr  <= gnt_nxt ? m1_addr  : m0_addr;
               cmd_wdata <= gnt_nxt ? m1_wdata : m0_wdata;
            end
            ACCESS: begin
               io_data <= cmd_io0 ? DATA_W'(btn_in) : (cmd_io1 ? hex_out : '0);
               if (cmd_io1 && cmd_we) hex_out <= cmd_wdata;
            end
            LATCH: if (!cmd_we) begin
               if (gnt) m1_rdata <= cmd_ram ? ram_rdata : io_data;
               else     m0_rdata <= cmd_ram ? ram_rdata : io_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomized bench for ram_bus_arbiter against a transaction-level model
// that tracks each granted transaction by its age in cycles.
module tb_ram_bus_arbiter;
   localparam int AW = 12, DW = 16, DEPTH = 64;

   logic clk = 1'b0, res;
   logic m0_req, m0_we, m1_req, m1_we, m0_ack, m1_ack;
   logic [AW-1:0] m0_addr, m1_addr, ram_addr;
   logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_wdata, ram_rdata, hex_out;
   logic ram_sel, ram_ld;
   logic [1:0] btn_in;

   ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .res(res),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack),
      .ram_sel(ram_sel), .ram_ld(ram_ld), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .btn_in(btn_in), .hex_out(hex_out));

   always #5 clk = ~clk;

   // synchronous RAM with a preload port
   logic [DW-1:0] ram [0:DEPTH-1];
   logic          pre_we;
   logic [5:0]    pre_addr;
   logic [DW-1:0] pre_data;
   always @(posedge clk) begin
      if (pre_we) ram[pre_addr] <= pre_data;
      else if (ram_sel) begin
         if (ram_ld) ram_rdata <= ram[ram_addr[5:0]];
         else        ram[ram_addr[5:0]] <= ram_wdata;
      end
   end

   int nchk = 0, npass = 0;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s got %h expected %h", tag, got, exp);
   endtask

   // model: age t of the in-flight transaction (0 = none, 1..3 = cycles since grant)
   int            t = 0;
   bit            mm, mwe, last = 1'b1;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mwd, mrd, mhex;
   logic [DW-1:0] mem [0:DEPTH-1];
   logic [DW-1:0] exp_rd [2];

   function automatic bit in_ram(logic [AW-1:0] a);
      return a >= AW'(2) && a < AW'(DEPTH);
   endfunction

   task automatic step();
      bit sel_e;
      @(posedge clk); #1;
      if (res) begin
         t = 0; last = 1'b1; mhex = '0; exp_rd[0] = '0; exp_rd[1] = '0;
      end else if (t == 0) begin
         if (m0_req || m1_req) begin
            if (m0_req && m1_req) begin mm = !last; last = mm; end
            else mm = m1_req;
            mwe   = mm ? m1_we    : m0_we;
            maddr = mm ? m1_addr  : m0_addr;
            mwd   = mm ? m1_wdata : m0_wdata;
            t = 1;
         end
      end else if (t == 1) begin
         if (maddr == 0)         mrd = {14'b0, btn_in};
         else if (maddr == 1)    mrd = mhex;
         else if (in_ram(maddr)) mrd = mem[maddr[5:0]];
         else                    mrd = '0;
         if (mwe && maddr == 1)         mhex = mwd;
         if (mwe && in_ram(maddr))      mem[maddr[5:0]] = mwd;
         t = 2;
      end else if (t == 2) begin
         if (!mwe) exp_rd[mm] = mrd;
         t = 3;
      end else t = 0;
      sel_e = (t == 1) && in_ram(maddr);
      chk("ram_sel", 32'(ram_sel), 32'(sel_e));
      chk("ram_ld", 32'(ram_ld), 32'(sel_e && !mwe));
      chk("ram_addr", 32'(ram_addr), sel_e ? 32'(maddr) : 0);
      chk("ram_wdata", 32'(ram_wdata), sel_e ? 32'(mwd) : 0);
      chk("m0_ack", 32'(m0_ack), 32'(t == 3 && !mm));
      chk("m1_ack", 32'(m1_ack), 32'(t == 3 && mm));
      chk("m0_rdata", 32'(m0_rdata), 32'(exp_rd[0]));
      chk("m1_rdata", 32'(m1_rdata), 32'(exp_rd[1]));
      chk("hex_out", 32'(hex_out), 32'(mhex));
   endtask

   task automatic drive(bit x, bit rq, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
      if (x) begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = d; end
      else   begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = d; end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return AW'(1);
         4:       return AW'(DEPTH);
         5:       return AW'($urandom_range(DEPTH + 1, 4095));
         default: return AW'($urandom_range(2, DEPTH - 1));
      endcase
   endfunction

   int selcnt;
   // one transaction from an idle bus; returns the cycle its ack appeared in
   task automatic run_txn(bit x, bit we, logic [AW-1:0] a, logic [DW-1:0] d, output int lat);
      bit got = 1'b0;
      drive(x, 1'b1, we, a, d);
      lat = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         step(); lat++;
         if (ram_sel) selcnt++;
         got = x ? m1_ack : m0_ack;
      end
      if (!got) chk("ack_timeout", 0, 1);
      drive(x, 1'b0, 1'b0, '0, '0);
      step();
   endtask

   initial begin
      int lat;
      res = 1'b1; btn_in = 2'b00; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      exp_rd[0] = '0; exp_rd[1] = '0; mhex = '0;
      drive(0, 1'b1, 1'b0, AW'(2), '0);
      drive(1, 1'b1, 1'b0, AW'(3), '0);

      // preload under reset with both requests high: everything must stay 0
      for (int i = 0; i < DEPTH; i++) begin
         pre_we = 1'b1; pre_addr = 6'(i);
         pre_data = (i == 5) ? 16'hBEEF : (i == 2) ? 16'h1111 : (i == 3) ? 16'h2222 : DW'($urandom);
         mem[i] = pre_data;
         step();
      end
      pre_we = 1'b0;
      res = 1'b0;

      // both masters reading continuously: strict alternation from m0
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("rr_m0_ack", 32'(m0_ack), 32'(i == 3 || i == 11));
         chk("rr_m1_ack", 32'(m1_ack), 32'(i == 7 || i == 15));
      end
      chk("rr_m0_data", 32'(m0_rdata), 32'h1111);
      chk("rr_m1_data", 32'(m1_rdata), 32'h2222);
      drive(0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0);
      step(); step();

      selcnt = 0;
      run_txn(0, 1'b0, AW'(5), '0, lat);
      chk("rd_latency", 32'(lat), 3);
      chk("rd_sel_count", 32'(selcnt), 1);
      chk("rd_data", 32'(m0_rdata), 32'hBEEF);

      btn_in = 2'b10; selcnt = 0;
      run_txn(1, 1'b1, AW'(1), 16'h1234, lat);
      chk("io_hex", 32'(hex_out), 32'h1234);
      run_txn(0, 1'b0, AW'(1), '0, lat);
      chk("io_rd_hex", 32'(m0_rdata), 32'h1234);
      run_txn(0, 1'b0, AW'(0), '0, lat);
      chk("io_rd_btn", 32'(m0_rdata), 32'h0002);
      chk("io_no_sel", 32'(selcnt), 0);

      selcnt = 0;
      run_txn(0, 1'b1, AW'(64), 16'hFFFF, lat);
      chk("oor_wr_lat", 32'(lat), 3);
      run_txn(0, 1'b0, AW'(64), '0, lat);
      chk("oor_rd_lat", 32'(lat), 3);
      chk("oor_rd_data", 32'(m0_rdata), 0);
      chk("oor_no_sel", 32'(selcnt), 0);

      // reset during the LATCH cycle of an m1 read
      drive(1, 1'b1, 1'b0, AW'(5), '0);
      step(); step();
      res = 1'b1;
      step();
      chk("rst_no_ack", 32'(m1_ack), 0);
      res = 1'b0; drive(1, 1'b0, 1'b0, '0, '0);
      step();
      run_txn(1, 1'b0, AW'(5), '0, lat);
      chk("rst_new_lat", 32'(lat), 3);
      chk("rst_new_data", 32'(m1_rdata), 32'hBEEF);

      // random traffic, occasional reset
      for (int n = 0; n < 2000; n++) begin
         step();
         for (int x = 0; x < 2; x++) begin
            bit rq = x ? m1_req : m0_req;
            if (rq) begin
               if (t == 3 && mm == bit'(x)) begin
                  if ($urandom_range(0, 1) == 1)
                     drive(bit'(x), 1'b1, bit'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
                  else drive(bit'(x), 1'b0, 1'b0, '0, '0);
               end
            end else if ($urandom_range(0, 2) == 0)
               drive(bit'(x), 1'b1, bit'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
         end
         btn_in = 2'($urandom);
         res = ($urandom_range(0, 199) == 0);
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
